// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the EX-stage multiply/divide sequencer.
// Holds the op and state encodings, the divide iteration count, and sign helpers.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } mdOp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } mdState_e;

   localparam int DIV_CYCLES = 32;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

   // Magnitude of x when treated as signed; raw value otherwise.
   function automatic logic [31:0] absVal(input logic [31:0] x,
                                          input logic        isSigned);
      return (isSigned && x[31]) ? neg32(x) : x;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX <-> muldiv request/result bundle.
// master = EX side (start/op/a/b/flush out), slave = sequencer (stall/done/busy/hilo out).
interface muldiv_ctrl_if;
   import muldiv_pkg::*;

   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        stall;
   logic        done;
   logic        busy;
   logic [63:0] hilo;

   modport master (
      output start, op, a, b, flush,
      input  stall, done, busy, hilo
   );

   modport slave (
      input  start, op, a, b, flush,
      output stall, done, busy, hilo
   );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter: unsigned 32-bit restoring divider core, one quotient bit per step.
// Ports: load (capture dividend/divisor), step (one iteration), quotient, remainder.
module div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] dvsr;
   logic [32:0] shifted;
   logic [32:0] diff;

   // Partial remainder is always < dvsr, so a set diff[32] means a borrow.
   assign shifted = {remainder, quotient[31]};
   assign diff    = shifted - {1'b0, dvsr};

   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         dvsr      <= '0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         dvsr      <= divisor;
      end else if (step) begin
         if (!diff[32]) begin
            remainder <= diff[31:0];
            quotient  <= {quotient[30:0], 1'b1};
         end else begin
            remainder <= shifted[31:0];
            quotient  <= {quotient[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU.
// Ports: clk, rst (sync, active-high), bus (muldiv_ctrl_if.slave: start/op/a/b/flush
// in; stall/done/busy/hilo out). Optional MULDIV_DIV_EARLY_EXIT_EN finishes a divide
// in one cycle when |a| < |b|.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_ctrl_if.slave   bus
);

   mdState_e    state;
   mdState_e    stateNext;
   logic [4:0]  cnt;
   logic [4:0]  cntNext;
   logic [63:0] hiloReg;
   logic [63:0] hiloNext;
   logic        hiloLoad;
   logic        mulLoad;
   logic        divLoad;
   logic        divStep;
   logic        negQ;
   logic        negR;

   mdOp_e       opIn;
   logic        isMul;
   logic        isSigned;
   logic [31:0] absA;
   logic [31:0] absB;

   assign opIn     = mdOp_e'(bus.op);
   assign isMul    = (opIn == MD_MULT) || (opIn == MD_MULTU);
   assign isSigned = (opIn == MD_MULT) || (opIn == MD_DIV);
   assign absA     = absVal(bus.a, isSigned);
   assign absB     = absVal(bus.b, isSigned);

   // Multiplier: 33x33 signed product, sign-extended to 64 bits so the
   // truncated result is exact; stage 0 captures at accept, then shifts.
   logic [32:0]        mulA;
   logic [32:0]        mulB;
   logic signed [63:0] mulProd;
   logic [63:0]        mulPipe [MUL_LATENCY];

   assign mulA    = {isSigned & bus.a[31], bus.a};
   assign mulB    = {isSigned & bus.b[31], bus.b};
   assign mulProd = $signed({{31{mulA[32]}}, mulA})
                  * $signed({{31{mulB[32]}}, mulB});

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MUL_LATENCY; i++) mulPipe[i] <= '0;
      end else begin
         if (mulLoad) mulPipe[0] <= mulProd;
         for (int i = 1; i < MUL_LATENCY; i++) mulPipe[i] <= mulPipe[i-1];
      end
   end

   logic [31:0] divQ;
   logic [31:0] divR;

   div_iter uDiv (
      .clk       (clk),
      .rst       (rst),
      .load      (divLoad),
      .step      (divStep),
      .dividend  (absA),
      .divisor   (absB),
      .quotient  (divQ),
      .remainder (divR)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         hiloReg <= '0;
         negQ    <= 1'b0;
         negR    <= 1'b0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (hiloLoad) hiloReg <= hiloNext;
         if (divLoad) begin
            negQ <= isSigned & (bus.a[31] ^ bus.b[31]);
            negR <= isSigned & bus.a[31];
         end
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      hiloLoad  = 1'b0;
      hiloNext  = hiloReg;
      mulLoad   = 1'b0;
      divLoad   = 1'b0;
      divStep   = 1'b0;
      if (bus.flush) begin
         stateNext = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (isMul) begin
                     mulLoad   = 1'b1;
                     stateNext = ST_MUL;
                     cntNext   = 5'(MUL_LATENCY - 1);
                  end else if (bus.b == '0) begin
                     hiloLoad  = 1'b1;
                     hiloNext  = {bus.a, 32'hFFFF_FFFF};
                     stateNext = ST_DONE;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
                  end else if (absA < absB) begin
                     // q=0 and r=a, sign of a already in place.
                     hiloLoad  = 1'b1;
                     hiloNext  = {bus.a, 32'h0};
                     stateNext = ST_DONE;
`endif
                  end else begin
                     divLoad   = 1'b1;
                     stateNext = ST_DIV;
                     cntNext   = 5'(DIV_CYCLES - 1);
                  end
               end
            end
            ST_MUL: begin
               if (cnt == '0) begin
                  hiloLoad  = 1'b1;
                  hiloNext  = mulPipe[MUL_LATENCY-1];
                  stateNext = ST_DONE;
               end else begin
                  cntNext = cnt - 5'd1;
               end
            end
            ST_DIV: begin
               divStep = 1'b1;
               if (cnt == '0) stateNext = ST_FIX;
               else           cntNext   = cnt - 5'd1;
            end
            ST_FIX: begin
               hiloLoad  = 1'b1;
               hiloNext  = {negR ? neg32(divR) : divR,
                            negQ ? neg32(divQ) : divQ};
               stateNext = ST_DONE;
            end
            ST_DONE: begin
               stateNext = ST_IDLE;
            end
            default: begin
               stateNext = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.stall = ~bus.flush &
                      (((state == ST_IDLE) & bus.start) |
                       (state == ST_MUL) |
                       (state == ST_DIV) |
                       (state == ST_FIX));
   assign bus.done  = (state == ST_DONE);
   assign bus.busy  = (state != ST_IDLE);
   assign bus.hilo  = hiloReg;

endmodule
